serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
//  Sequential counterpart of the combinational full-adder datapath.
//  Used by game logic (row/score/position arithmetic) where area matters more than latency.
//  start/busy/done handshake; the result is held until the next operation completes.
// PARAMETERS
//  WIDTH  8  operand and result width in bits; legal range 2..32
// PORTS
//  clk     input   1      system clock; all state changes on posedge
//  reset   input   1      synchronous, active-low reset (0 = reset, sampled on posedge clk)
//  start   input   1      request; sampled only in IDLE or DONE
//  a       input   WIDTH  minuend; captured on an accepted start
//  b       input   WIDTH  subtrahend; captured on an accepted start
//  busy    output  1      1 while in RUN
//  done    output  1      one-cycle pulse when diff/borrow/zero update
//  diff    output  WIDTH  a - b mod 2^WIDTH (clamped when SERIAL_SUB_SAT_EN is defined)
//  borrow  output  1      1 when a < b (unsigned)
//  zero    output  1      1 when the unclamped diff equals 0
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, diff=0, borrow=0, zero=0; internal shift regs, count, bflop cleared.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: start=1 -> load sa=a, sb=b, bflop=0, count=0; go to RUN.
//   RUN: each cycle:
//    d  = sa[0]^sb[0]^bflop
//    bflop <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bflop)
//    sa, sb shift right; d shifts into the MSB of the result shift reg sr
//    count increments; after WIDTH RUN cycles go to DONE.
//   DONE (1 cycle): diff<=final sr, borrow<=bflop, zero<=(sr==0), done=1.
//    start=1 here -> accepted exactly as in IDLE (back-to-back, next state RUN);
//    otherwise -> IDLE.
//  Latency: start accepted on edge N -> busy=1 from N+1 through N+WIDTH;
//   done=1 and outputs valid at N+WIDTH+1. Throughput: one op per WIDTH+1 cycles.
//  start while in RUN: ignored; operands not re-captured; no error flag.
//  a/b change after acceptance: no effect on the operation in flight.
//  diff/borrow/zero: change only in DONE; held stable otherwise (including IDLE).
//  busy and done: never both 1.
//  count: $clog2(WIDTH)+1 bits; no wrap; compare against WIDTH-1.
//  Reset mid-operation: abort at the next edge; all outputs return to reset values; prior result lost.
//  Reset has priority over start on the same edge.
// CONFIGURATION
//  SERIAL_SUB_SAT_EN defined: in DONE, if bflop=1 then diff<=0; borrow still <=1;
//   zero still reflects the unclamped result.
//  SERIAL_SUB_SAT_EN undefined: diff is always the modular result. Timing identical in both builds.
// TESTING (WIDTH=8)
//  1. reset low 2 cycles -> busy=0, done=0, diff=0x00, borrow=0, zero=0.
//  2. start a=0x5A b=0x21 -> busy for 8 cycles, done pulse at cycle 9: diff=0x39, borrow=0, zero=0.
//  3. a=0x10 b=0x20 -> diff=0xF0 borrow=1 (SAT_EN: diff=0x00 borrow=1); a=0x33 b=0x33 -> diff=0x00, zero=1.
//  4. start pulse at cycle 3 of RUN with a=0xFF b=0x00 -> ignored; first result is delivered unchanged; no extra done pulse.
//  5. start held high continuously, a=0x09 b=0x04 -> done every 9 cycles, diff=0x05 each time; busy low only in DONE.
//  6. reset low at RUN cycle 4 -> next cycle busy=0, diff=0x00; no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// Handshake: start is accepted in IDLE or DONE. busy is high for WIDTH cycles, then done
// pulses for one cycle while diff/borrow/zero update. The result is held until the next
// operation completes.
// Optional build macro SERIAL_SUB_SAT_EN: a result that borrows is clamped to zero. borrow and
// zero still describe the unclamped difference.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,   // synchronous, active-low
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  // One extra bit so the counter can hold WIDTH without wrapping.
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sr_q;
  logic             bflop_q;
  logic [CntW-1:0]  count_q;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             zero_q;

  logic             d_bit;
  logic             bflop_d;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] result_d;
  logic             last_bit;

  // Full-subtractor slice on the current LSBs, plus the next result shift-register value.
  always_comb begin
    d_bit    = sa_q[0] ^ sb_q[0] ^ bflop_q;
    bflop_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bflop_q);
    sr_d     = {d_bit, sr_q[WIDTH-1:1]};
    last_bit = (count_q == CntLast);
`ifdef SERIAL_SUB_SAT_EN
    result_d = bflop_d ? '0 : sr_d;
`else
    result_d = sr_d;
`endif
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      bflop_q  <= 1'b0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            sr_q    <= '0;
            bflop_q <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRun: begin
          // start is ignored here; the operands in flight are never re-captured.
          sa_q    <= {1'b0, sa_q[WIDTH-1:1]};
          sb_q    <= {1'b0, sb_q[WIDTH-1:1]};
          sr_q    <= sr_d;
          bflop_q <= bflop_d;
          count_q <= count_q + CntW'(1);
          if (last_bit) begin
            // The last bit's result is folded straight into the outputs, so they are
            // valid in the same cycle that done is high.
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= result_d;
            borrow_q <= bflop_d;
            zero_q   <= (sr_d == '0);
            state_q  <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8). The stimulus pushes hand-computed results
// with the cycle in which done must appear. An independent monitor pops and compares on every
// done pulse.
module tb_serial_subtractor;

  localparam int unsigned W = 8;
`ifdef SERIAL_SUB_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    int unsigned  c;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borrow(borrow),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("borrow", 32'(borrow), 32'(e.bo));
        chk("zero", 32'(zero), 32'(e.z));
        chk("done_cycle", cyc, e.c);
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  // Issue one operation; expected diff is given as the modular result.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic ez);
    exp_t e;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.d  = (Sat && eb) ? '0 : ed;
    e.bo = eb;
    e.z  = ez;
    e.c  = cyc + W;
    sb_q.push_back(e);
  endtask

  task automatic wait_empty();
    int k;
    for (k = 0; k < 40; k++) begin
      @(posedge clk);
      #2;
      if (sb_q.size() == 0) break;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL timeout: got %0d pending results expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    int busy_cnt;
    exp_t e;
    reset = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;

    // 1. Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'h00);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    reset = 1'b1;

    // 2-3. Basic vectors
    run_op(8'h5A, 8'h21, 8'h39, 1'b0, 1'b0);
    wait_empty();
    run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    wait_empty();
    run_op(8'h33, 8'h33, 8'h00, 1'b0, 1'b1);
    wait_empty();
    run_op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    wait_empty();
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    wait_empty();

    // 4. start pulse during RUN is ignored and operand changes have no effect
    run_op(8'h5A, 8'h21, 8'h39, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hFF;
    b = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_empty();
    repeat (12) @(posedge clk);
    #1;
    chk("no_extra_done", 32'(sb_q.size()), 32'd0);

    // 5. start held high: back-to-back ops, busy low only in the DONE cycle
    busy_cnt = 0;
    @(negedge clk);
    a = 8'h09;
    b = 8'h04;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) start = 1'b0;
      e.d  = 8'h05;
      e.bo = 1'b0;
      e.z  = 1'b0;
      e.c  = cyc + W;
      sb_q.push_back(e);
      for (int j = 0; j < 9; j++) begin
        @(negedge clk);
        if (busy === 1'b1) busy_cnt++;
      end
    end
    chk("held_busy_cycles", 32'(busy_cnt), 32'd24);
    wait_empty();

    // 6. Reset mid-operation aborts it and clears outputs
    @(negedge clk);
    a = 8'h5A;
    b = 8'h21;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'h00);
    chk("abort_borrow", 32'(borrow), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(8'h80, 8'h7F, 8'h01, 1'b0, 1'b0);
    wait_empty();

    // Result held stable in IDLE
    repeat (5) @(negedge clk);
    chk("hold_diff", 32'(diff), 32'h01);
    chk("hold_busy", 32'(busy), 32'd0);

    repeat (12) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
